// File: rtl/reg_wb_arbiter_pkg.sv
// Shared CPU register-file definitions and the write-request type used by the
// writeback arbiter and its long-latency result FIFO.
package reg_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_req_t;

  typedef enum logic [1:0] {
    SelNone = 2'd0,
    SelWb   = 2'd1,
    SelFifo = 2'd2
  } sel_e;

  function automatic logic is_real_reg(input logic [REG_ADDR_W-1:0] addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_fifo.sv
// Synchronous FIFO buffering long-latency register writes until the arbiter
// grants them the register-file write port.
module reg_wb_arbiter_fifo
  import reg_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_push,
  input  wr_req_t i_push_data,
  input  logic    i_pop,
  output wr_req_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = DEPTH[PTR_W:0];

  wr_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // Guard against caller misuse; the arbiter already gates both.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Sole driver of the register-file write port: merges in-order writeback with
// buffered long-latency results and tracks registers awaiting those results.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wb_we,
  input  logic [REG_ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0]     i_wb_data,
  output logic                  o_wb_stall,
  input  logic                  i_ll_valid,
  output logic                  o_ll_ready,
  input  logic [REG_ADDR_W-1:0] i_ll_addr,
  input  logic [DATA_W-1:0]     i_ll_data,
  input  logic                  i_iss_valid,
  input  logic [REG_ADDR_W-1:0] i_iss_addr,
  output logic                  o_iss_ready,
  input  logic [REG_ADDR_W-1:0] i_qa_addr,
  output logic                  o_busy_a,
  input  logic [REG_ADDR_W-1:0] i_qb_addr,
  output logic                  o_busy_b,
  output logic                  o_rf_we,
  output logic [REG_ADDR_W-1:0] o_rf_addr_w,
  output logic [DATA_W-1:0]     o_rf_data_w
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = STARVE_LIMIT[CNT_W-1:0];

  wr_req_t w_fifo_head;
  wr_req_t w_push_data;
  logic    w_fifo_full;
  logic    w_fifo_empty;
  logic    w_push;
  logic    w_pop;
  sel_e    w_sel;
  logic    w_starve_inc;
  logic    w_starve_hit;
  logic    w_iss_set;
  logic    w_ll_clear;

  logic                  r_rf_we;
  logic                  r_rf_from_fifo;
  logic [REG_ADDR_W-1:0] r_rf_addr;
  logic [DATA_W-1:0]     r_rf_data;
  logic                  r_wb_stall;
  logic [CNT_W-1:0]      r_starve_cnt;
  logic [NUM_REGS-1:0]   r_pending;
  logic [NUM_REGS-1:0]   w_pending_d;

  // Writes to r0 are architecturally void, so they never occupy a FIFO slot.
  assign w_push      = i_ll_valid && !w_fifo_full && is_real_reg(i_ll_addr);
  assign w_push_data = '{addr: i_ll_addr, data: i_ll_data};
  assign o_ll_ready  = !w_fifo_full;

  reg_wb_arbiter_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (w_push),
    .i_push_data(w_push_data),
    .i_pop      (w_pop),
    .o_head     (w_fifo_head),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  always_comb begin
    w_sel = SelNone;
    if (r_wb_stall && !w_fifo_empty) begin
      w_sel = SelFifo;
    end else if (i_wb_we && is_real_reg(i_wb_addr)) begin
      w_sel = SelWb;
    end else if (!w_fifo_empty) begin
      w_sel = SelFifo;
    end
  end

  assign w_pop        = (w_sel == SelFifo);
  assign w_starve_inc = !w_fifo_empty && (w_sel == SelWb);
  assign w_starve_hit = w_starve_inc && ((r_starve_cnt + CNT_ONE) == CNT_LIMIT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_starve_cnt <= '0;
      r_wb_stall   <= 1'b0;
    end else begin
      r_wb_stall <= w_starve_hit;
      if (w_pop || r_wb_stall) begin
        r_starve_cnt <= '0;
      end else if (w_starve_inc) begin
        r_starve_cnt <= r_starve_cnt + CNT_ONE;
      end
    end
  end

  // Address/data hold when idle so the regfile port does not toggle needlessly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rf_we        <= 1'b0;
      r_rf_from_fifo <= 1'b0;
      r_rf_addr      <= '0;
      r_rf_data      <= '0;
    end else begin
      r_rf_we        <= (w_sel != SelNone);
      r_rf_from_fifo <= (w_sel == SelFifo);
      case (w_sel)
        SelWb: begin
          r_rf_addr <= i_wb_addr;
          r_rf_data <= i_wb_data;
        end
        SelFifo: begin
          r_rf_addr <= w_fifo_head.addr;
          r_rf_data <= w_fifo_head.data;
        end
        default: begin
          r_rf_addr <= r_rf_addr;
          r_rf_data <= r_rf_data;
        end
      endcase
    end
  end

  assign o_rf_we     = r_rf_we;
  assign o_rf_addr_w = r_rf_addr;
  assign o_rf_data_w = r_rf_data;
  assign o_wb_stall  = r_wb_stall;

  assign o_iss_ready = !is_real_reg(i_iss_addr) || !r_pending[i_iss_addr];
  assign o_busy_a    = is_real_reg(i_qa_addr) && r_pending[i_qa_addr];
  assign o_busy_b    = is_real_reg(i_qb_addr) && r_pending[i_qb_addr];

  assign w_iss_set  = i_iss_valid && o_iss_ready && is_real_reg(i_iss_addr);
  // Clear as the regfile captures the FIFO write, so busy drops once the value is readable.
  assign w_ll_clear = r_rf_we && r_rf_from_fifo;

  always_comb begin
    w_pending_d = r_pending;
    if (w_ll_clear) begin
      w_pending_d[r_rf_addr] = 1'b0;
    end
    if (w_iss_set) begin
      w_pending_d[i_iss_addr] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_d;
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: expected regfile writes go into a queue that
// a negedge monitor drains; timing-sensitive flags are checked inline.
module tb_reg_wb_arbiter;
  import reg_wb_arbiter_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]     wb_data;
  logic                  wb_stall;
  logic                  ll_valid;
  logic                  ll_ready;
  logic [REG_ADDR_W-1:0] ll_addr;
  logic [DATA_W-1:0]     ll_data;
  logic                  iss_valid;
  logic [REG_ADDR_W-1:0] iss_addr;
  logic                  iss_ready;
  logic [REG_ADDR_W-1:0] qa_addr;
  logic                  busy_a;
  logic [REG_ADDR_W-1:0] qb_addr;
  logic                  busy_b;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_addr_w;
  logic [DATA_W-1:0]     rf_data_w;

  int      n_checks = 0;
  int      n_fail   = 0;
  wr_req_t exp_q[$];
  wr_req_t mon_e;

  always #5 clk = ~clk;

  reg_wb_arbiter #(
    .DEPTH       (4),
    .STARVE_LIMIT(4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wb_we    (wb_we),
    .i_wb_addr  (wb_addr),
    .i_wb_data  (wb_data),
    .o_wb_stall (wb_stall),
    .i_ll_valid (ll_valid),
    .o_ll_ready (ll_ready),
    .i_ll_addr  (ll_addr),
    .i_ll_data  (ll_data),
    .i_iss_valid(iss_valid),
    .i_iss_addr (iss_addr),
    .o_iss_ready(iss_ready),
    .i_qa_addr  (qa_addr),
    .o_busy_a   (busy_a),
    .i_qb_addr  (qb_addr),
    .o_busy_b   (busy_b),
    .o_rf_we    (rf_we),
    .o_rf_addr_w(rf_addr_w),
    .o_rf_data_w(rf_data_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [REG_ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_we     = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    ll_valid  = 1'b0;
    ll_addr   = '0;
    ll_data   = '0;
    iss_valid = 1'b0;
    iss_addr  = '0;
  endtask

  task automatic drive_wb(input logic [REG_ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_we   = 1'b1;
    wb_addr = a;
    wb_data = d;
  endtask

  task automatic drive_ll(input logic [REG_ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ll_valid = 1'b1;
    ll_addr  = a;
    ll_data  = d;
  endtask

  // Every regfile write must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rf_write: got addr %0d data 0x%0h, want no write", rf_addr_w, rf_data_w);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_addr_w !== mon_e.addr || rf_data_w !== mon_e.data) begin
          n_fail++;
          $display("FAIL rf_write: got addr %0d data 0x%0h, want addr %0d data 0x%0h",
                   rf_addr_w, rf_data_w, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    qa_addr = '0;
    qb_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset mid-operation: two queued results and pending[8] are discarded.
    tick();
    drive_wb(5'd1, 32'hA0);
    drive_ll(5'd12, 32'hC);
    iss_valid = 1'b1;
    iss_addr  = 5'd8;
    qa_addr   = 5'd8;
    expect_wr(5'd1, 32'hA0);
    tick();
    drive_wb(5'd1, 32'hA1);
    drive_ll(5'd13, 32'hD);
    iss_valid = 1'b0;
    #2;
    chk("busy_a_after_issue", busy_a, 1'b1);
    tick();
    rst = 1'b1;
    idle();
    #2;
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_rf_addr", rf_addr_w, 5'd0);
    chk("rst_rf_data", rf_data_w, 32'h0);
    chk("rst_wb_stall", wb_stall, 1'b0);
    chk("rst_ll_ready", ll_ready, 1'b1);
    for (int r = 0; r < 32; r++) begin
      qa_addr = r[REG_ADDR_W-1:0];
      #1;
      chk("rst_busy_a", busy_a, 1'b0);
    end
    tick();
    rst = 1'b0;
    qa_addr = 5'd8;
    repeat (4) tick();
    chk("post_rst_busy8", busy_a, 1'b0);
    chk("post_rst_ll_ready", ll_ready, 1'b1);

    // Pipeline writeback appears on rf_* exactly one cycle later.
    tick();
    drive_wb(5'd5, 32'h0000_1234);
    expect_wr(5'd5, 32'h0000_1234);
    tick();
    idle();
    #2;
    chk("wb_lat_we", rf_we, 1'b1);
    chk("wb_lat_addr", rf_addr_w, 5'd5);
    chk("wb_lat_data", rf_data_w, 32'h1234);
    tick();
    #2;
    chk("wb_one_cycle_we", rf_we, 1'b0);
    chk("wb_hold_addr", rf_addr_w, 5'd5);

    // Issue to r8, result returns through the FIFO, busy clears after commit.
    tick();
    iss_valid = 1'b1;
    iss_addr  = 5'd8;
    #2;
    chk("iss_ready_free", iss_ready, 1'b1);
    chk("busy_a_pre", busy_a, 1'b0);
    tick();
    iss_valid = 1'b0;
    drive_ll(5'd8, 32'hDEAD_BEEF);
    expect_wr(5'd8, 32'hDEAD_BEEF);
    #2;
    chk("busy_a_set", busy_a, 1'b1);
    chk("iss_ready_pending", iss_ready, 1'b0);
    iss_addr  = 5'd0;
    iss_valid = 1'b1;
    #1;
    chk("iss_ready_r0", iss_ready, 1'b1);
    tick();
    idle();
    #2;
    chk("busy_a_queued", busy_a, 1'b1);
    chk("ll_no_write_yet", rf_we, 1'b0);
    tick();
    #2;
    chk("ll_write_we", rf_we, 1'b1);
    chk("ll_write_addr", rf_addr_w, 5'd8);
    chk("busy_a_during_write", busy_a, 1'b1);
    tick();
    qb_addr = 5'd0;
    #2;
    chk("busy_a_cleared", busy_a, 1'b0);
    chk("busy_b_r0", busy_b, 1'b0);

    // Pipeline beats a waiting FIFO head; a wb to r0 does not block it.
    tick();
    drive_ll(5'd9, 32'h2);
    tick();
    idle();
    drive_wb(5'd3, 32'h1);
    expect_wr(5'd3, 32'h1);
    expect_wr(5'd9, 32'h2);
    tick();
    idle();
    #2;
    chk("prio_first_addr", rf_addr_w, 5'd3);
    tick();
    #2;
    chk("prio_second_addr", rf_addr_w, 5'd9);
    chk("prio_second_data", rf_data_w, 32'h2);
    tick();
    drive_ll(5'd11, 32'h33);
    expect_wr(5'd11, 32'h33);
    tick();
    idle();
    drive_wb(5'd0, 32'h77);
    tick();
    idle();
    #2;
    chk("wb_r0_fifo_we", rf_we, 1'b1);
    chk("wb_r0_fifo_addr", rf_addr_w, 5'd11);
    tick();
    drive_ll(5'd0, 32'h55);
    tick();
    idle();
    repeat (3) tick();

    // Starvation: continuous wb fills the FIFO, then one stall cycle drains it.
    for (int k = 0; k < 5; k++) begin
      tick();
      drive_wb(5'd2, 32'h100 + k);
      drive_ll(5'(16 + k), 32'hE0 + k);
      expect_wr(5'd2, 32'h100 + k);
      if (k == 0) begin
        #2;
        chk("starve_ready_c0", ll_ready, 1'b1);
      end
    end
    #2;
    chk("starve_full_ready", ll_ready, 1'b0);
    chk("starve_no_stall_c4", wb_stall, 1'b0);
    tick();
    drive_wb(5'd2, 32'h105);
    expect_wr(5'd16, 32'hE0);
    expect_wr(5'd2, 32'h105);
    for (int k = 1; k < 5; k++) expect_wr(5'(16 + k), 32'hE0 + k);
    #2;
    chk("starve_stall_c5", wb_stall, 1'b1);
    chk("starve_ready_c5", ll_ready, 1'b0);
    tick();
    #2;
    chk("starve_stall_c6", wb_stall, 1'b0);
    chk("starve_ready_c6", ll_ready, 1'b1);
    tick();
    idle();
    #2;
    chk("starve_stall_c7", wb_stall, 1'b0);
    repeat (8) tick();
    chk("drained_ready", ll_ready, 1'b1);
    chk("exp_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
